// File: rtl/vfat_activity_shaper_if.sv
// Bundles the raw VFAT S-bit inputs, shaping configuration and shaped activity outputs.
// The master drives stimulus and configuration; the slave (the shaper) drives activity and the onset count.
interface vfat_activity_shaper_if #(
  parameter int NUM_VFATS = 24,
  parameter int STRETCH_W = 4,
  parameter int DEAD_W    = 4,
  parameter int CNT_W     = 16
);
  logic [NUM_VFATS-1:0] vfat_or_i;
  logic [NUM_VFATS-1:0] mask_i;
  logic [STRETCH_W-1:0] stretch_len_i;
  logic [DEAD_W-1:0]    deadtime_i;
  logic                 cnt_reset_i;
  logic [NUM_VFATS-1:0] active_vfats_o;
  logic                 any_active_o;
  logic [CNT_W-1:0]     event_cnt_o;

  modport master (
    output vfat_or_i, mask_i, stretch_len_i, deadtime_i, cnt_reset_i,
    input  active_vfats_o, any_active_o, event_cnt_o
  );

  modport slave (
    input  vfat_or_i, mask_i, stretch_len_i, deadtime_i, cnt_reset_i,
    output active_vfats_o, any_active_o, event_cnt_o
  );
endinterface

// File: rtl/vfat_activity_shaper.sv
// Per-VFAT S-bit shaper: mask, non-retriggerable stretch, dead time, saturating onset count; latency 2 cycles.
// No backpressure: free-running at the 40 MHz fabric clock, every input cycle is consumed.
module vfat_activity_shaper #(
  parameter int NUM_VFATS = 24,
  parameter int STRETCH_W = 4,
  parameter int DEAD_W    = 4,
  parameter int CNT_W     = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  vfat_activity_shaper_if.slave  bus
);

  localparam int CW = (STRETCH_W > DEAD_W) ? STRETCH_W : DEAD_W;

  typedef enum logic [1:0] {IDLE, ACTIVE, DEAD} state_t;

  logic [NUM_VFATS-1:0] in_q;
  state_t               state_q [NUM_VFATS];
  state_t               state_d [NUM_VFATS];
  logic [CW-1:0]        cnt_q   [NUM_VFATS];
  logic [CW-1:0]        cnt_d   [NUM_VFATS];
  logic [NUM_VFATS-1:0] rearm;
  logic [NUM_VFATS-1:0] onset;
  logic [NUM_VFATS-1:0] active;
  logic [CNT_W-1:0]     event_cnt_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      in_q        <= '0;
      event_cnt_q <= '0;
      for (int n = 0; n < NUM_VFATS; n++) begin
        state_q[n] <= IDLE;
        cnt_q[n]   <= '0;
      end
    end else begin
      in_q <= bus.vfat_or_i & ~bus.mask_i;
      for (int n = 0; n < NUM_VFATS; n++) begin
        state_q[n] <= state_d[n];
        cnt_q[n]   <= cnt_d[n];
      end
      if (bus.cnt_reset_i)
        event_cnt_q <= '0;
      else if ((|onset) && (event_cnt_q != {CNT_W{1'b1}}))
        event_cnt_q <= event_cnt_q + CNT_W'(1);
    end
  end

  // A channel leaving a pulse or dead period is evaluated as IDLE in the same
  // cycle, so a held input retriggers with no extra idle cycle in between.
  always_comb begin
    rearm = '0;
    onset = '0;
    for (int n = 0; n < NUM_VFATS; n++) begin
      state_d[n] = state_q[n];
      cnt_d[n]   = cnt_q[n];
      case (state_q[n])
        IDLE: rearm[n] = 1'b1;
        ACTIVE: begin
          if (cnt_q[n] != '0) begin
            cnt_d[n] = cnt_q[n] - CW'(1);
          end else if (bus.deadtime_i != '0) begin
            state_d[n] = DEAD;
            cnt_d[n]   = CW'(bus.deadtime_i - DEAD_W'(1));
          end else begin
            rearm[n] = 1'b1;
          end
        end
        DEAD: begin
          if (cnt_q[n] != '0)
            cnt_d[n] = cnt_q[n] - CW'(1);
          else
            rearm[n] = 1'b1;
        end
        default: begin
          state_d[n] = IDLE;
          cnt_d[n]   = '0;
        end
      endcase
      if (rearm[n]) begin
        state_d[n] = IDLE;
        if (in_q[n]) begin
          state_d[n] = ACTIVE;
          cnt_d[n]   = CW'(bus.stretch_len_i);
          onset[n]   = 1'b1;
        end
      end
    end
  end

  always_comb begin
    active = '0;
    for (int n = 0; n < NUM_VFATS; n++)
      active[n] = (state_q[n] == ACTIVE);
  end

  assign bus.active_vfats_o = active;
  assign bus.any_active_o   = |active;
  assign bus.event_cnt_o    = event_cnt_q;

endmodule

// File: tb/tb_vfat_activity_shaper.sv
// Directed bench for vfat_activity_shaper: hand-computed expectations checked with immediate assertions.
module tb_vfat_activity_shaper;
  localparam int NV = 24;

  logic clock = 1'b0;
  logic reset = 1'b1;
  int checks = 0;
  int failures = 0;

  vfat_activity_shaper_if #(.NUM_VFATS(NV), .STRETCH_W(4), .DEAD_W(4), .CNT_W(16)) bus ();

  vfat_activity_shaper #(.NUM_VFATS(NV), .STRETCH_W(4), .DEAD_W(4), .CNT_W(16)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    bus.vfat_or_i     = '0;
    bus.mask_i        = '0;
    bus.stretch_len_i = 4'd0;
    bus.deadtime_i    = 4'd0;
    bus.cnt_reset_i   = 1'b0;

    // reset state
    reset = 1'b1;
    step();
    step();
    check("rst_active", 32'(bus.active_vfats_o), 32'h0);
    check("rst_any", 32'(bus.any_active_o), 32'h0);
    check("rst_cnt", 32'(bus.event_cnt_o), 32'h0);
    reset = 1'b0;
    step();

    // 1: single-cycle pulse on channel 5, stretch 0, dead 0
    bus.vfat_or_i = 24'(1) << 5;
    step();
    bus.vfat_or_i = '0;
    check("t1_lat1", 32'(bus.active_vfats_o), 32'h0);
    step();
    check("t1_high", 32'(bus.active_vfats_o), 32'h20);
    check("t1_any", 32'(bus.any_active_o), 32'h1);
    check("t1_cnt", 32'(bus.event_cnt_o), 32'h1);
    step();
    check("t1_low", 32'(bus.active_vfats_o), 32'h0);

    // 2: held input, stretch 3 dead 2 -> 4 high / 2 low, 4 onsets
    bus.cnt_reset_i = 1'b1;
    step();
    bus.cnt_reset_i = 1'b0;
    check("t2_clr", 32'(bus.event_cnt_o), 32'h0);
    bus.stretch_len_i = 4'd3;
    bus.deadtime_i    = 4'd2;
    for (int n = 1; n <= 28; n++) begin
      bus.vfat_or_i = (n <= 20) ? 24'h1 : 24'h0;
      step();
      check($sformatf("t2_pat%0d", n), 32'(bus.active_vfats_o[0]),
            32'((n >= 2 && n <= 23 && ((n - 2) % 6) < 4) ? 1 : 0));
    end
    check("t2_cnt", 32'(bus.event_cnt_o), 32'h4);

    // 3a: masked channel 7 never fires
    bus.mask_i    = 24'(1) << 7;
    bus.vfat_or_i = 24'(1) << 7;
    step();
    bus.vfat_or_i = '0;
    step();
    check("t3_mask_out", 32'(bus.active_vfats_o), 32'h0);
    step();
    check("t3_mask_cnt", 32'(bus.event_cnt_o), 32'h4);

    // 3b: masking channel 8 mid-pulse does not truncate it
    bus.mask_i        = '0;
    bus.stretch_len_i = 4'd5;
    bus.deadtime_i    = 4'd4;
    bus.vfat_or_i     = 24'(1) << 8;
    for (int n = 1; n <= 9; n++) begin
      step();
      if (n == 2) bus.mask_i = 24'(1) << 8;
      if (n >= 2)
        check($sformatf("t3_ch8_%0d", n), 32'(bus.active_vfats_o[8]),
              32'((n <= 7) ? 1 : 0));
    end
    check("t3_ch8_cnt", 32'(bus.event_cnt_o), 32'h5);
    bus.vfat_or_i = '0;
    bus.mask_i    = '0;
    repeat (6) step();

    // 4: all channels together
    bus.stretch_len_i = 4'd0;
    bus.deadtime_i    = 4'd0;
    bus.vfat_or_i     = '1;
    step();
    bus.vfat_or_i = '0;
    check("t4_early", 32'(bus.active_vfats_o), 32'h0);
    step();
    check("t4_all", 32'(bus.active_vfats_o), 32'hFFFFFF);
    check("t4_any", 32'(bus.any_active_o), 32'h1);
    check("t4_cnt", 32'(bus.event_cnt_o), 32'h6);
    step();
    check("t4_off", 32'(bus.active_vfats_o), 32'h0);
    check("t4_any_off", 32'(bus.any_active_o), 32'h0);

    // 6: reset during a stretched pulse, then a fresh pulse with no dead time
    bus.stretch_len_i = 4'd7;
    bus.deadtime_i    = 4'd3;
    bus.vfat_or_i     = 24'(1) << 3;
    step();
    bus.vfat_or_i = '0;
    step();
    step();
    step();
    check("t6_mid", 32'(bus.active_vfats_o), 32'h8);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6_rst_out", 32'(bus.active_vfats_o), 32'h0);
    check("t6_rst_cnt", 32'(bus.event_cnt_o), 32'h0);
    bus.vfat_or_i = 24'(1) << 3;
    step();
    bus.vfat_or_i = '0;
    check("t6_lat", 32'(bus.active_vfats_o), 32'h0);
    for (int n = 7; n <= 15; n++) begin
      step();
      check($sformatf("t6_pulse%0d", n), 32'(bus.active_vfats_o),
            (n <= 14) ? 32'h8 : 32'h0);
    end
    repeat (5) step();

    // 5: saturation of the onset counter, then clear beating a coincident onset
    bus.stretch_len_i = 4'd0;
    bus.deadtime_i    = 4'd0;
    bus.cnt_reset_i   = 1'b1;
    step();
    bus.cnt_reset_i = 1'b0;
    check("t5_clr", 32'(bus.event_cnt_o), 32'h0);
    bus.vfat_or_i = 24'h1;
    for (int n = 1; n <= 65535; n++) begin
      step();
      if (n == 10) begin
        check("t5_run_cnt", 32'(bus.event_cnt_o), 32'd9);
        check("t5_run_act", 32'(bus.active_vfats_o), 32'h1);
      end
    end
    check("t5_near", 32'(bus.event_cnt_o), 32'hFFFE);
    step();
    check("t5_max", 32'(bus.event_cnt_o), 32'hFFFF);
    for (int n = 0; n < 4; n++) begin
      step();
      check($sformatf("t5_hold%0d", n), 32'(bus.event_cnt_o), 32'hFFFF);
    end
    bus.cnt_reset_i = 1'b1;
    step();
    check("t5_clr_wins", 32'(bus.event_cnt_o), 32'h0);
    bus.cnt_reset_i = 1'b0;
    step();
    check("t5_resume", 32'(bus.event_cnt_o), 32'h1);
    bus.vfat_or_i = '0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
